// File: rtl/alu_share_if.sv
// rtl/alu_share_if.sv - request/response and shared-ALU signal bundle for alu_share_arbiter
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;

  logic [2:0]       alu_ctr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    output alu_ctr, alu_a, alu_b
  );

  // requesters plus ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_ctr, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port round-robin/fixed-priority sharer for one combinational ALU
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter bit RR    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             grant_q;
  logic             last_grant_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             win0;
  logic             win1;
  logic             rsp_fire;

  // Arbitration: on contention port 0 wins unless round-robin says it went last
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state_q == IDLE) begin
      win0 = bus.req0_valid && (!bus.req1_valid || !RR || last_grant_q);
      win1 = bus.req1_valid && !win0;
    end
  end

  // Next-state and output decode; ALU inputs are held at zero unless an op is in flight
  always_comb begin
    state_d         = state_q;
    rsp_fire        = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_result = result_q;
    bus.rsp1_result = result_q;
    bus.rsp0_zero   = zero_q;
    bus.rsp1_zero   = zero_q;
    bus.alu_ctr     = 3'b000;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = win0;
        bus.req1_ready = win1;
        if (win0 || win1) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.alu_ctr = op_q;
        bus.alu_a   = a_q;
        bus.alu_b   = b_q;
        state_d     = RESP;
      end
      RESP: begin
        bus.alu_ctr    = op_q;
        bus.alu_a      = a_q;
        bus.alu_b      = b_q;
        bus.rsp0_valid = !grant_q;
        bus.rsp1_valid = grant_q;
        rsp_fire       = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, operand latch on handshake, result capture at the end of ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (win0 || win1) begin
        grant_q <= win1;
        op_q    <= win1 ? bus.req1_op : bus.req0_op;
        a_q     <= win1 ? bus.req1_a  : bus.req0_a;
        b_q     <= win1 ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == ISSUE) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
      end
      if (rsp_fire) begin
        last_grant_q <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (round-robin and fixed-priority)
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_if #(.WIDTH(W)) bus ();
  alu_share_if #(.WIDTH(W)) fbus ();

  alu_share_arbiter #(.WIDTH(W), .RR(1'b1)) dut    (.clk(clk), .reset(reset), .bus(bus.slave));
  alu_share_arbiter #(.WIDTH(W), .RR(1'b0)) dut_fp (.clk(clk), .reset(reset), .bus(fbus.slave));

  // ALU stubs: plain adder
  assign bus.alu_result  = bus.alu_a + bus.alu_b;
  assign bus.alu_zero    = (bus.alu_a + bus.alu_b) == '0;
  assign fbus.alu_result = fbus.alu_a + fbus.alu_b;
  assign fbus.alu_zero   = (fbus.alu_a + fbus.alu_b) == '0;

  typedef struct {
    int         port;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       zero;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int fp_grants = 0;
  bit done = 1'b0;

  // stimulus state for the round-robin instance
  logic [1:0]   v;
  logic [2:0]   op [2];
  logic [W-1:0] a  [2];
  logic [W-1:0] b  [2];
  logic [1:0]   rr;

  // reference model: phase of the single in-flight op and who is preferred on contention
  int    phase = 0;
  int    prio  = 0;
  item_t cur;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req0_valid = v[0];
    bus.req0_op    = op[0];
    bus.req0_a     = a[0];
    bus.req0_b     = b[0];
    bus.req1_valid = v[1];
    bus.req1_op    = op[1];
    bus.req1_a     = a[1];
    bus.req1_b     = b[1];
    bus.rsp0_ready = rr[0];
    bus.rsp1_ready = rr[1];
  endtask

  task automatic evaluate();
    int w;
    logic [W-1:0] s;
    w = -1;
    case (phase)
      0: begin
        if (v[0] && (!v[1] || prio == 0)) w = 0;
        else if (v[1]) w = 1;
        chk("req0_ready", W'(bus.req0_ready), W'(w == 0));
        chk("req1_ready", W'(bus.req1_ready), W'(w == 1));
        chk("idle_alu_ctr", W'(bus.alu_ctr), '0);
        chk("idle_alu_a", bus.alu_a, '0);
        chk("idle_alu_b", bus.alu_b, '0);
        chk("idle_rsp0_valid", W'(bus.rsp0_valid), '0);
        chk("idle_rsp1_valid", W'(bus.rsp1_valid), '0);
      end
      default: begin
        chk("busy_req0_ready", W'(bus.req0_ready), '0);
        chk("busy_req1_ready", W'(bus.req1_ready), '0);
        chk("alu_ctr", W'(bus.alu_ctr), W'(cur.op));
        chk("alu_a", bus.alu_a, cur.a);
        chk("alu_b", bus.alu_b, cur.b);
        chk("rsp0_valid", W'(bus.rsp0_valid), W'(phase == 2 && cur.port == 0));
        chk("rsp1_valid", W'(bus.rsp1_valid), W'(phase == 2 && cur.port == 1));
      end
    endcase
    if (reset) begin
      phase = 0;
      prio  = 0;
      sb.delete();
    end else begin
      case (phase)
        0: if (w >= 0) begin
          s = a[w] + b[w];
          cur.port = w;
          cur.op   = op[w];
          cur.a    = a[w];
          cur.b    = b[w];
          cur.res  = s;
          cur.zero = (s == '0);
          sb.push_back(cur);
          v[w]  = 1'b0;
          phase = 1;
        end
        1: phase = 2;
        default: if (rr[cur.port]) begin
          phase = 0;
          prio  = 1 - cur.port;
        end
      endcase
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((v[0] || v[1] || phase != 0) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (v[0] || v[1] || phase != 0) begin
      errors++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v     = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    v[p]  = 1'b1;
    op[p] = o;
    a[p]  = x;
    b[p]  = y;
  endtask

  // response monitor: every presented response must match the head of the scoreboard
  initial begin
    item_t e;
    int    p;
    forever begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=valid required=none at %0t", $time);
        end else begin
          e = sb[0];
          p = bus.rsp1_valid ? 1 : 0;
          chk("rsp_both_valid", W'(bus.rsp0_valid && bus.rsp1_valid), '0);
          chk("rsp_port", W'(p), W'(e.port));
          chk("rsp_result", p == 1 ? bus.rsp1_result : bus.rsp0_result, e.res);
          chk("rsp_zero", W'(p == 1 ? bus.rsp1_zero : bus.rsp0_zero), W'(e.zero));
          if (p == 1 ? bus.rsp1_ready : bus.rsp0_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // fixed-priority instance: both ports always requesting, port 0 must win every time
  initial begin
    fbus.req0_valid = 1'b1;
    fbus.req0_op    = 3'b010;
    fbus.req0_a     = 32'd5;
    fbus.req0_b     = 32'd7;
    fbus.req1_valid = 1'b1;
    fbus.req1_op    = 3'b011;
    fbus.req1_a     = 32'd1;
    fbus.req1_b     = 32'd1;
    fbus.rsp0_ready = 1'b1;
    fbus.rsp1_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!done && !reset) begin
        chk("fp_req1_ready", W'(fbus.req1_ready), '0);
        chk("fp_rsp1_valid", W'(fbus.rsp1_valid), '0);
        if (fbus.req0_valid && fbus.req0_ready) fp_grants++;
        if (fbus.rsp0_valid) chk("fp_rsp0_result", fbus.rsp0_result, 32'd12);
      end
    end
  end

  initial begin
    v     = 2'b00;
    rr    = 2'b11;
    op[0] = '0; op[1] = '0;
    a[0]  = '0; a[1]  = '0;
    b[0]  = '0; b[1]  = '0;
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_rsp0_result", bus.rsp0_result, '0);
    chk("reset_rsp1_zero", W'(bus.rsp1_zero), '0);

    // port 0 alone
    set_req(0, 3'b000, 32'd1, 32'd1);
    run_until_idle("t1_single", 20);

    // contention from reset: port 0 first, then port 1, then port 0 again
    do_reset();
    set_req(0, 3'b000, 32'd3, 32'd1);
    set_req(1, 3'b000, 32'd0, 32'd0);
    run_until_idle("t2_pair", 20);
    set_req(0, 3'b001, 32'd10, 32'd20);
    set_req(1, 3'b010, 32'd30, 32'd40);
    run_until_idle("t2_pair2", 20);

    // back-pressure on port 1 while port 0 keeps requesting
    set_req(1, 3'b100, $urandom, $urandom);
    rr = 2'b01;
    step();
    step();
    set_req(0, 3'b011, $urandom, $urandom);
    repeat (10) step();
    rr = 2'b11;
    run_until_idle("t4_backpressure", 20);

    // reset while the op is in ISSUE
    set_req(0, 3'b110, 32'd9, 32'd9);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    set_req(1, 3'b101, 32'd100, 32'd23);
    run_until_idle("t5_after_reset", 20);

    // unused op code and wrap-around to zero
    set_req(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
    run_until_idle("t6_wrap", 20);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(0, 2) == 0) begin
          op[p] = 3'($urandom_range(0, 7));
          a[p]  = $urandom;
          case ($urandom_range(0, 3))
            0:       b[p] = -a[p];
            1:       b[p] = 32'd1;
            default: b[p] = $urandom;
          endcase
          v[p] = 1'b1;
        end else if (v[p] && $urandom_range(0, 15) == 0) begin
          v[p] = 1'b0;
        end
        rr[p] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rr = 2'b11;
    v  = 2'b00;
    run_until_idle("random_drain", 20);
    chk("sb_empty", W'(sb.size()), '0);

    done = 1'b1;
    chk("fp_grants_min", W'(fp_grants >= 50), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
